// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain loader.
package scan_pkg;

   localparam int unsigned SCAN_BYTE_BITS = 8;
   localparam int unsigned SCAN_CNT_W     = $clog2(SCAN_BYTE_BITS);

   localparam logic SCAN_MODE_READ  = 1'b0;
   localparam logic SCAN_MODE_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } scan_state_t;

endpackage

// File: rtl/scan_byte_shifter.sv
// Byte-wide serialiser/deserialiser between the loader FSM and the scan chain.
// Bits leave tx_sr and enter rx_sr LSB-first, one per shift.
module scan_byte_shifter
   import scan_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      load,
   input  logic [SCAN_BYTE_BITS-1:0] load_data,
   input  logic                      shift,
   input  logic                      recirc,
   input  logic                      scan_out,
   output logic                      scan_bit,
   output logic [SCAN_BYTE_BITS-1:0] rx_data,
   output logic                      last_bit
);

   logic [SCAN_BYTE_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [SCAN_BYTE_BITS-1:0] rx_sr_q, rx_sr_d;
   logic [SCAN_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;

   // Next-state for the shift registers and bit counter; counter wraps per byte.
   always_comb begin
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      bit_cnt_d = bit_cnt_q;
      if (clear) begin
         bit_cnt_d = '0;
      end
      if (load) begin
         tx_sr_d = load_data;
      end
      if (shift) begin
         rx_sr_d   = {scan_out, rx_sr_q[SCAN_BYTE_BITS-1:1]};
         tx_sr_d   = tx_sr_q >> 1;
         bit_cnt_d = bit_cnt_q + SCAN_CNT_W'(1);
      end
   end

   // Shifter state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Read mode feeds the tail straight back into the head so the chain is restored.
   always_comb begin
      scan_bit = recirc ? scan_out : tx_sr_q[0];
      rx_data  = rx_sr_q;
      last_bit = (bit_cnt_q == SCAN_CNT_W'(SCAN_BYTE_BITS - 1));
   end

endmodule

// File: rtl/scan_chain_loader.sv
// Host-side scan chain initiator: pauses the core, exchanges a full chain
// image with the host as byte streams, one chain bit per SHIFT cycle.
module scan_chain_loader
   import scan_pkg::*;
#(
   parameter int unsigned CHAIN_BYTES = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode_write,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       done,
   input  logic       proc_enable_in,
   output logic       proc_enable_out,
   output logic       scan_enable,
   output logic       scan_in,
   input  logic       scan_out
);

   localparam int unsigned BCW = (CHAIN_BYTES > 1) ? $clog2(CHAIN_BYTES) : 1;

   scan_state_t    state_q, state_d;
   logic           mode_q, mode_d;
   logic [BCW-1:0] byte_cnt_q, byte_cnt_d;

   logic sh_clear, sh_load, sh_shift;
   logic scan_bit, last_bit;
   logic [SCAN_BYTE_BITS-1:0] rx_data;

   scan_byte_shifter u_shifter (
      .clk       (clk),
      .rst       (rst),
      .clear     (sh_clear),
      .load      (sh_load),
      .load_data (in_data),
      .shift     (sh_shift),
      .recirc    (mode_q == SCAN_MODE_READ),
      .scan_out  (scan_out),
      .scan_bit  (scan_bit),
      .rx_data   (rx_data),
      .last_bit  (last_bit)
   );

   // Transaction FSM: next state, byte counter and shifter controls.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      byte_cnt_d = byte_cnt_q;
      sh_clear   = 1'b0;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d     = mode_write;
               byte_cnt_d = '0;
               sh_clear   = 1'b1;
               state_d    = (mode_write == SCAN_MODE_WRITE) ? LOAD : SHIFT;
            end
         end
         LOAD: begin
            if (in_valid) begin
               sh_load = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_shift = 1'b1;
            if (last_bit) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (byte_cnt_q == BCW'(CHAIN_BYTES - 1)) begin
                  state_d = DONE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BCW'(1);
                  state_d    = (mode_q == SCAN_MODE_WRITE) ? LOAD : SHIFT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= SCAN_MODE_READ;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   // Outputs decoded from the state register; busy drops as done pulses.
   always_comb begin
      busy            = (state_q == LOAD) || (state_q == SHIFT) || (state_q == EMIT);
      done            = (state_q == DONE);
      in_ready        = (state_q == LOAD);
      out_valid       = (state_q == EMIT);
      out_data        = rx_data;
      scan_enable     = (state_q == SHIFT);
      scan_in         = (state_q == SHIFT) & scan_bit;
      proc_enable_out = proc_enable_in & ~busy;
   end

endmodule

// File: doc/scan_chain_loader.md
# scan_chain_loader

Host-side initiator for the processor's scan chain. Pauses the core, serially shifts a full chain image in on `scan_in`, and captures the old image from `scan_out`. Exchanges the image with the host as byte streams using valid/ready handshakes. Sits between the host/debug port and the control unit and datapath scan chain, and gates `processor_enable` to the core.

## Interface
- `CHAIN_BYTES`, default 4: chain length in bytes. Chain bits = 8*CHAIN_BYTES. Must be ≥1.
- `clk` in 1: clock; chain flops share it.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to begin a transaction; sampled only in IDLE.
- `mode_write` in 1: sampled with `start`. 1 = load host image; 0 = read-only, recirculate `scan_out` to `scan_in`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8: host image bytes, first byte = chain bits 7:0.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8: captured chain bytes, same ordering.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at transaction end.
- `proc_enable_in` in 1: enable from the board/top.
- `proc_enable_out` out 1: `proc_enable_in & ~busy`, combinational, to the core.
- `scan_enable` out 1, `scan_in` out 1: to the chain head.
- `scan_out` in 1: from the chain tail.

## Operation
- States: IDLE, LOAD, SHIFT, EMIT, DONE.
- IDLE
  - `start` latches the mode, clears `byte_cnt` and `bit_cnt`, and sets `busy`.
  - Next state is LOAD if write mode, SHIFT if read mode.
  - `start` in any other state is ignored.
- LOAD
  - `in_ready`=1.
  - On `in_valid&in_ready`: `tx_sr`<=`in_data`, go to SHIFT.
- SHIFT, one bit per cycle
  - `scan_enable`=1.
  - `scan_in` = `tx_sr[0]` (write) or `scan_out` (read).
  - `rx_sr` <= {`scan_out`, `rx_sr[7:1]`}; `tx_sr` >>= 1; `bit_cnt`++.
  - After the 8th bit (`bit_cnt`==7), go to EMIT.
- EMIT
  - `out_valid`=1, `out_data`=`rx_sr`, held stable until accepted.
  - On `out_ready`: if `byte_cnt`==CHAIN_BYTES-1, go to DONE; else `byte_cnt`++ and go to LOAD (write) or SHIFT (read).
- DONE: `done`=1 for one cycle, `busy`<=0, go to IDLE.
- Bit order is LSB-first in both directions. The first bit out of `scan_out` is the tail flop's value before any shift.
- In read mode the chain returns to its original contents after 8*CHAIN_BYTES shifts. `in_ready` stays 0 throughout.
- `scan_enable` is never 1 unless `busy`=1, so the core is always paused while the chain shifts.
- `in_valid` outside LOAD and `out_ready` outside EMIT are don't-care.

## Timing
- Reset (`rst`=0 at a clk edge) applies these values:
  - state IDLE; `busy`, `done`, `scan_enable`, `scan_in`, `in_ready`, `out_valid` = 0; `out_data`=0x00; counters 0.
- Reset mid-transaction aborts immediately. The chain is left partially shifted, which is accepted. `proc_enable_out` follows `proc_enable_in` from the next cycle.
- `busy` rises the cycle after `start`; `proc_enable_out` falls in that same cycle.
- Per-byte latency with an always-ready host:
  - write: 1 cycle LOAD + 8 SHIFT + 1 EMIT = 10 cycles;
  - read: 9 cycles.
- Full write transaction: 10*CHAIN_BYTES + 1 (DONE) cycles after `busy` rises.
- Back-pressure on either stream stalls the FSM with `scan_enable`=0. No bits are lost and no extra shifts occur.
- `done` and `busy` falling occur in the same cycle. A new `start` is accepted the cycle after DONE.

## Structure
- Shared package `scan_pkg`:
  - state enum `scan_state_t` (IDLE, LOAD, SHIFT, EMIT, DONE);
  - constant `SCAN_BYTE_BITS`=8;
  - mode constants `SCAN_MODE_READ`=0, `SCAN_MODE_WRITE`=1.
- Sub-module `scan_byte_shifter`: holds `tx_sr`, `rx_sr` and the 3-bit `bit_cnt`, with ports load, shift, recirc and `last_bit`. The top module holds the FSM, `byte_cnt` and the handshakes.
- Bench model: behavioural shift chain of 8*CHAIN_BYTES flops, enabled by `scan_enable`.

## Test plan
- Write, CHAIN_BYTES=4, chain preset 0x0F0E0D0C:
  - send 0x11,0x22,0x33,0x44;
  - expect `out_data` 0x0C,0x0D,0x0E,0x0F, chain = 0x44332211, `done` at cycle 41 after `busy`.
- Read mode on chain 0xA5A55A5A: expect out 0x5A,0x5A,0xA5,0xA5; chain unchanged; `in_ready` never 1.
- Hold `out_ready`=0 for 5 cycles in EMIT: `out_data` stable, `scan_enable`=0, total latency +5.
- `rst`=0 during SHIFT of byte 2: next cycle all outputs at reset values, `proc_enable_out`=`proc_enable_in`.
- `start` asserted while busy: ignored, byte count unchanged, exactly one `done`.
- `proc_enable_in`=1 throughout: `proc_enable_out`=0 exactly while `busy`=1, and `scan_enable`&`proc_enable_out` never both 1.
